// File: rtl/maxterm_extractor_pkg.sv
// Shared definitions for the maxterm extractor: FSM encoding and width helpers.
package maxterm_extractor_pkg;

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

  function automatic int unsigned num_rows(input int unsigned n_vars);
    return 32'd1 << n_vars;
  endfunction

  // One extra bit so an all-zero function (every row a maxterm) does not wrap.
  function automatic int unsigned count_width(input int unsigned n_vars);
    return n_vars + 32'd1;
  endfunction

endpackage

// File: rtl/maxterm_extractor_settle_timer.sv
// Down-counter holding the probe for Settle cycles before the sample edge.
module settle_timer #(
  parameter int unsigned Settle = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  output logic expired_o
);

  localparam int unsigned CntW = (Settle > 1) ? $clog2(Settle) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CntW'(Settle - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/maxterm_extractor.sv
// Sweeps all 2^N_VARS input rows of a function under test and records its maxterms.
module maxterm_extractor
  import maxterm_extractor_pkg::*;
#(
  parameter int unsigned N_VARS = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               f_in,
  output logic [N_VARS-1:0]                  probe,
  output logic                               busy,
  output logic                               done,
  output logic                               valid,
  output logic [num_rows(N_VARS)-1:0]        maxterm_mask,
  output logic [count_width(N_VARS)-1:0]     maxterm_count
);

  localparam int unsigned NumRows = num_rows(N_VARS);
  localparam int unsigned CntW    = count_width(N_VARS);

  state_e              state_q, state_d;
  logic [N_VARS-1:0]   idx_q, idx_d;
  logic [N_VARS-1:0]   probe_q, probe_d;
  logic [NumRows-1:0]  mask_q, mask_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;

  logic is_last;
  logic miss;
  logic timer_load;
  logic timer_expired;

  assign is_last = &idx_q;
  assign miss    = ~f_in;

  // Reload on every entry into StDrive.
  assign timer_load = ((state_q == StIdle) && start) || ((state_q == StSample) && !is_last);

  settle_timer #(
    .Settle (SETTLE)
  ) u_settle_timer (
    .clk_i     (clk),
    .reset_i   (reset),
    .load_i    (timer_load),
    .expired_o (timer_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StDrive;
      StDrive:  if (timer_expired) state_d = StSample;
      StSample: state_d = is_last ? StDone : StDrive;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    probe_d = probe_q;
    mask_d  = mask_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          idx_d   = '0;
          probe_d = '0;
          mask_d  = '0;
          count_d = '0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StSample: begin
        mask_d[idx_q] = miss;
        count_d       = count_q + {{(CntW-1){1'b0}}, miss};
        if (is_last) begin
          probe_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          probe_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      probe_q <= '0;
      mask_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      probe_q <= probe_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign probe         = probe_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign valid         = valid_q;
  assign maxterm_mask  = mask_q;
  assign maxterm_count = count_q;

endmodule

// File: tb/tb_maxterm_extractor.sv
// Scoreboard bench: directed sweeps push expected results, monitors check on done.
module tb_maxterm_extractor;

  logic       clk = 1'b0;
  logic       reset, start, start2;
  logic [7:0] fmask, fmask2;
  logic       f_in, f_in2;

  logic [2:0] probe, probe2;
  logic       busy, done, valid, busy2, done2, valid2;
  logic [7:0] mask, mask2;
  logic [3:0] count, count2;

  typedef struct {
    logic [7:0] mask;
    logic [3:0] cnt;
    int         acc;
  } exp_t;

  exp_t sb[$];
  exp_t sb2[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Function under test: F(i) = 0 exactly where fmask[i] is set.
  assign f_in = ~fmask[probe];
  always @(posedge clk) f_in2 <= ~fmask2[probe2];

  maxterm_extractor #(.N_VARS(3), .SETTLE(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .f_in          (f_in),
    .probe         (probe),
    .busy          (busy),
    .done          (done),
    .valid         (valid),
    .maxterm_mask  (mask),
    .maxterm_count (count)
  );

  maxterm_extractor #(.N_VARS(3), .SETTLE(3)) dut2 (
    .clk           (clk),
    .reset         (reset),
    .start         (start2),
    .f_in          (f_in2),
    .probe         (probe2),
    .busy          (busy2),
    .done          (done2),
    .valid         (valid2),
    .maxterm_mask  (mask2),
    .maxterm_count (count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && busy) chk("valid_low_while_busy", {31'd0, valid}, 32'd0);
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("mask", {24'd0, mask}, {24'd0, e.mask});
        chk("count", {28'd0, count}, {28'd0, e.cnt});
        chk("valid_at_done", {31'd0, valid}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("probe_at_done", {29'd0, probe}, 32'd0);
        chk("done_latency", cyc - e.acc, 32'd16);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done2) begin
      if (sb2.size() == 0) begin
        chk("unexpected_done2", 32'd1, 32'd0);
      end else begin
        e = sb2.pop_front();
        chk("mask2", {24'd0, mask2}, {24'd0, e.mask});
        chk("count2", {28'd0, count2}, {28'd0, e.cnt});
        chk("valid2_at_done", {31'd0, valid2}, 32'd1);
        chk("done2_latency", cyc - e.acc, 32'd32);
      end
    end
  end

  task automatic pulse_start(input logic [7:0] em, input logic [3:0] ec);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    sb.push_back('{em, ec, cyc});
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (done) return;
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Waits through the DONE cycle into IDLE and checks results stay valid.
  task automatic finish_sweep();
    wait_done(40);
    @(posedge clk);
    #1 chk("valid_held_idle", {31'd0, valid}, 32'd1);
  endtask

  task automatic run(input logic [7:0] fm, input logic [7:0] em, input logic [3:0] ec);
    fmask = fm;
    pulse_start(em, ec);
    finish_sweep();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    reset  = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    fmask  = 8'h00;
    fmask2 = 8'hA3;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {14'd0, probe, busy, done, valid, mask, count}, 32'd0);
    chk("reset_state2", {14'd0, probe2, busy2, done2, valid2, mask2, count2}, 32'd0);
    @(negedge clk) reset = 1'b0;

    run(8'hC4, 8'hC4, 4'd3);

    // Probe steps 0..7, two cycles per row.
    fmask = 8'h3A;
    pulse_start(8'h3A, 4'd4);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      chk("probe_step", {29'd0, probe}, j >> 1);
    end
    finish_sweep();

    run(8'h00, 8'h00, 4'd0);
    run(8'hFF, 8'hFF, 4'd8);

    // Reset mid-sweep discards partial results.
    fmask = 8'hC4;
    pulse_start(8'hC4, 4'd3);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("midsweep_reset", {14'd0, probe, busy, done, valid, mask, count}, 32'd0);
    sb.delete();
    @(negedge clk) reset = 1'b0;
    run(8'hC4, 8'hC4, 4'd3);

    // Start held high: back-to-back sweeps every 18 cycles.
    fmask = 8'h66;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 k = cyc;
    sb.push_back('{8'h66, 4'd4, k});
    sb.push_back('{8'h66, 4'd4, k + 18});
    sb.push_back('{8'h66, 4'd4, k + 36});
    repeat (39) @(posedge clk);
    #1 start = 1'b0;
    finish_sweep();
    chk("b2b_all_done", sb.size(), 32'd0);

    // SETTLE=3 with a one-cycle-delayed function output.
    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    sb2.push_back('{8'hA3, 4'd4, cyc});
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(posedge clk);
        #1 seen = done2;
      end
      if (!seen) chk("done2_timeout", 32'd0, 32'd1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    chk("sb2_empty", sb2.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
